// File: rtl/mov_seq_pkg.sv
// mov_seq_pkg
// Shared definitions for the register-move sequencer: the FSM state
// encoding, the two-bit instruction mode codes and the number of PC
// increments an MVI instruction needs (opcode word plus immediate word).
package mov_seq_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_XFER,
    S_SWAP1,
    S_SWAP2,
    S_SWAP3,
    S_PCINC,
    S_DONE
  } state_t;

  localparam logic [1:0] MODE_MOV  = 2'b00;
  localparam logic [1:0] MODE_MVI  = 2'b01;
  localparam logic [1:0] MODE_XCHG = 2'b10;
  localparam logic [1:0] MODE_BLK  = 2'b11;

  localparam int MVI_PC_CYCLES = 2;

endpackage

// File: rtl/mov_seq_addr_gen.sv
// mov_seq_addr_gen
// Holds the latched source/destination register addresses and the block
// move beat counter for the sequencer.
// Ports:
//   clk, reset        clock and synchronous active-high reset (clears all)
//   load              capture src_in/dst_in/count_in
//   step              one block-move beat: both addresses +1, counter -1
//   src_in, dst_in    addresses presented with start
//   count_in          block-move beat count presented with start
//   src_q, dst_q      latched addresses (wrap modulo 2**ADDR_W)
//   cnt_q             remaining beats
//   cnt_zero          counter is zero
//   cnt_last          counter is one, i.e. the current beat is the final one
module mov_seq_addr_gen
  import mov_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic              step,
  input  logic [ADDR_W-1:0] src_in,
  input  logic [ADDR_W-1:0] dst_in,
  input  logic [CNT_W-1:0]  count_in,
  output logic [ADDR_W-1:0] src_q,
  output logic [ADDR_W-1:0] dst_q,
  output logic [CNT_W-1:0]  cnt_q,
  output logic              cnt_zero,
  output logic              cnt_last
);

  // Address increments rely on the natural ADDR_W-bit overflow to wrap
  // from the top register back to register 0.
  always_ff @(posedge clk) begin
    if (reset) begin
      src_q <= '0;
      dst_q <= '0;
      cnt_q <= '0;
    end else if (load) begin
      src_q <= src_in;
      dst_q <= dst_in;
      cnt_q <= count_in;
    end else if (step) begin
      src_q <= src_q + ADDR_W'(1);
      dst_q <= dst_q + ADDR_W'(1);
      cnt_q <= cnt_q - CNT_W'(1);
    end
  end

  assign cnt_zero = (cnt_q == '0);
  assign cnt_last = (cnt_q == CNT_W'(1));

endmodule

// File: rtl/mov_sequencer.sv
// mov_sequencer
// Control-only sequencer for register-move class instructions (MOV, MVI,
// XCHG, counted block move). One start/done handshake; all outputs are a
// Moore decode of the FSM state and the values latched at start.
// Ports:
//   clk, reset            clock and synchronous active-high reset
//   start                 request, honoured only in IDLE
//   mode                  00 MOV, 01 MVI, 10 XCHG, 11 BLK
//   src_addr, dst_addr    source / destination register
//   count                 block-move beat count
//   rf_rd_addr, rf_out_en register-file read address / bus drive
//   rf_wr_addr, rf_wr_en  register-file write address / capture
//   imm_sel               immediate drives the bus
//   tmp_ld, tmp_out_en    temp register capture / bus drive
//   pc_inc                advance the program counter this cycle
//   busy                  sequencer is not idle
//   done                  one-cycle completion pulse
module mov_sequencer
  import mov_seq_pkg::*;
#(
  parameter int ADDR_W = 3,
  parameter int CNT_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  count,
  output logic [ADDR_W-1:0] rf_rd_addr,
  output logic              rf_out_en,
  output logic [ADDR_W-1:0] rf_wr_addr,
  output logic              rf_wr_en,
  output logic              imm_sel,
  output logic              tmp_ld,
  output logic              tmp_out_en,
  output logic              pc_inc,
  output logic              busy,
  output logic              done
);

  state_t            state;
  state_t            state_next;
  logic [1:0]        mode_q;
  logic [1:0]        pc_cnt;
  logic              load;
  logic              step;
  logic              pc_last;
  logic [ADDR_W-1:0] src_q;
  logic [ADDR_W-1:0] dst_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              cnt_zero;
  logic              cnt_last;

  assign load = (state == S_IDLE) && start;
  assign step = (state == S_XFER) && (mode_q == MODE_BLK);

  mov_seq_addr_gen #(
    .ADDR_W (ADDR_W),
    .CNT_W  (CNT_W)
  ) u_addr_gen (
    .clk      (clk),
    .reset    (reset),
    .load     (load),
    .step     (step),
    .src_in   (src_addr),
    .dst_in   (dst_addr),
    .count_in (count),
    .src_q    (src_q),
    .dst_q    (dst_q),
    .cnt_q    (cnt_q),
    .cnt_zero (cnt_zero),
    .cnt_last (cnt_last)
  );

  // pc_cnt counts cycles spent in PCINC so MVI can stay for both the
  // opcode and the immediate word; it is cleared whenever PCINC is left.
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      mode_q <= MODE_MOV;
      pc_cnt <= '0;
    end else begin
      state <= state_next;
      if (load) begin
        mode_q <= mode;
      end
      if (state == S_PCINC) begin
        pc_cnt <= pc_cnt + 2'd1;
      end else begin
        pc_cnt <= '0;
      end
    end
  end

  assign pc_last = (mode_q != MODE_MVI) || (pc_cnt == 2'(MVI_PC_CYCLES - 1));

  // A block move whose counter is somehow zero inside XFER also exits,
  // so the FSM can never spin through a full counter wrap.
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (start) begin
          if (mode == MODE_XCHG) begin
            state_next = S_SWAP1;
          end else if ((mode == MODE_BLK) && (count == '0)) begin
            state_next = S_PCINC;
          end else begin
            state_next = S_XFER;
          end
        end
      end
      S_XFER: begin
        if ((mode_q != MODE_BLK) || cnt_last || cnt_zero) begin
          state_next = S_PCINC;
        end
      end
      S_SWAP1: state_next = S_SWAP2;
      S_SWAP2: state_next = S_SWAP3;
      S_SWAP3: state_next = S_PCINC;
      S_PCINC: begin
        if (pc_last) begin
          state_next = S_DONE;
        end
      end
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
  end

  // Only one of rf_out_en / imm_sel / tmp_out_en is ever set per state,
  // which keeps the shared bus free of contention.
  always_comb begin
    rf_rd_addr = '0;
    rf_out_en  = 1'b0;
    rf_wr_addr = '0;
    rf_wr_en   = 1'b0;
    imm_sel    = 1'b0;
    tmp_ld     = 1'b0;
    tmp_out_en = 1'b0;
    pc_inc     = 1'b0;
    done       = 1'b0;
    busy       = (state != S_IDLE);
    case (state)
      S_XFER: begin
        rf_wr_en   = 1'b1;
        rf_wr_addr = dst_q;
        if (mode_q == MODE_MVI) begin
          imm_sel = 1'b1;
        end else begin
          rf_out_en  = 1'b1;
          rf_rd_addr = src_q;
        end
      end
      S_SWAP1: begin
        rf_out_en  = 1'b1;
        rf_rd_addr = src_q;
        tmp_ld     = 1'b1;
      end
      S_SWAP2: begin
        rf_out_en  = 1'b1;
        rf_rd_addr = dst_q;
        rf_wr_en   = 1'b1;
        rf_wr_addr = src_q;
      end
      S_SWAP3: begin
        tmp_out_en = 1'b1;
        rf_wr_en   = 1'b1;
        rf_wr_addr = dst_q;
      end
      S_PCINC: pc_inc = 1'b1;
      S_DONE:  done   = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: doc/mov_sequencer.md
# mov_sequencer

Parametrised control sequencer for register-move class instructions in the microcontroller's execute stage. Successor to the single-mode MOV controller: one start/done handshake drives four modes: register move, move-immediate, register exchange, and counted block move. The block is control-only. It generates register-file read/write enables and addresses, temp-register and immediate-select strobes, and PC-increment pulses. The datapath (register file, temp register, immediate mux, PC) sits outside.

## Interface
Parameters:
- ADDR_W, 3, register-file address width (2**ADDR_W registers)
- CNT_W, 4, block-move count width

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  synchronous, active-high; priority over every other input
- start  in  1  request; sampled only in IDLE
- mode  in  2  00 MOV, 01 MVI, 10 XCHG, 11 BLK; latched with start
- src_addr  in  ADDR_W  source register; latched with start
- dst_addr  in  ADDR_W  destination register; latched with start
- count  in  CNT_W  BLK beat count; latched with start
- rf_rd_addr  out  ADDR_W  register-file read address
- rf_out_en  out  1  register file drives bus
- rf_wr_addr  out  ADDR_W  register-file write address
- rf_wr_en  out  1  register file captures bus
- imm_sel  out  1  bus driven by immediate instead of register file
- tmp_ld  out  1  temp register captures bus
- tmp_out_en  out  1  temp register drives bus
- pc_inc  out  1  PC += 1 this cycle
- busy  out  1  state != IDLE
- done  out  1  one-cycle completion pulse

## Operation
- States: IDLE, XFER, SWAP1, SWAP2, SWAP3, PCINC, DONE. All outputs are decoded from state and the latched registers (Moore). Unlisted outputs are 0.
- IDLE with start=1: latch mode/src/dst/count, then go to:
  - XFER for MOV, MVI, and BLK with count≠0
  - SWAP1 for XCHG
  - PCINC for BLK with count=0
- XFER:
  - rf_wr_en=1, rf_wr_addr=dst_q.
  - MOV/BLK: rf_out_en=1, rf_rd_addr=src_q.
  - MVI: imm_sel=1, rf_out_en=0.
  - MOV/MVI leave after one cycle to PCINC.
  - BLK: each beat, src_q and dst_q each +1, wrapping modulo 2**ADDR_W; beat counter −1. Exit to PCINC after the beat where the counter reaches 0.
- SWAP1: rf_out_en=1, rf_rd_addr=src_q, tmp_ld=1.
- SWAP2: rf_out_en=1, rf_rd_addr=dst_q, rf_wr_en=1, rf_wr_addr=src_q.
- SWAP3: tmp_out_en=1, rf_wr_en=1, rf_wr_addr=dst_q.
- PCINC: pc_inc=1.
  - MVI stays 2 cycles (opcode word + immediate word).
  - All other modes stay 1 cycle.
- DONE: done=1 for one cycle, then IDLE.
- XCHG with src=dst: runs the full sequence; the register is unchanged.
- BLK overlap: copy is strictly ascending, with no overlap correction. With dst inside (src, src+count) the source data propagates forward. This is the defined behaviour.
- start outside IDLE, including in DONE, is ignored and not queued. Input changes after latching have no effect.

## Timing
- Reset: any cycle with reset=1 sets state to IDLE at the next edge. All outputs are 0 the cycle after. Latched src/dst/count/mode are cleared to 0.
  - Mid-operation reset abandons the sequence: no done, no further pc_inc.
  - reset and start together: reset wins.
- Latency, start sampled at edge T:
  - MOV: XFER at T+1, PCINC T+2, done T+3
  - MVI: XFER T+1, PCINC T+2..T+3, done T+4
  - XCHG: SWAP1..3 at T+1..T+3, PCINC T+4, done T+5
  - BLK with count=N≥1: XFER T+1..T+N, PCINC T+N+1, done T+N+2
  - BLK with count=0: PCINC T+1, done T+2
- Earliest accepted back-to-back start is the cycle after done (IDLE). busy is high from T+1 through the done cycle inclusive.
- At most one of rf_out_en, imm_sel, tmp_out_en is high in any cycle (bus exclusivity). The bench asserts this every cycle.

## Structure
- Package mov_seq_pkg holds:
  - state enum
  - mode constants MODE_MOV/MODE_MVI/MODE_XCHG/MODE_BLK
  - MVI_PC_CYCLES=2
- Sub-module mov_seq_addr_gen contains the latched src/dst address registers with load, increment and wrap, plus the CNT_W down-counter with zero flag.
- The top level holds the FSM and output decode.

## Test plan
- MOV, src=2 dst=5 -> one XFER cycle with rd=2/wr=5 and rf_out_en=rf_wr_en=1; pc_inc once; done at T+3.
- MVI, dst=7 -> imm_sel=1 and rf_wr_en=1 with wr=7, rf_out_en=0; pc_inc high exactly 2 cycles; done at T+4.
- XCHG, src=1 dst=6 -> SWAP1 rd1+tmp_ld, SWAP2 rd6/wr1, SWAP3 tmp_out_en/wr6; done at T+5. With a register-file model, values are swapped.
- BLK, src=6 dst=0 count=3 with ADDR_W=3 -> rd 6,7,0 and wr 0,1,2 (wrap); done at T+5. Then BLK count=0 -> no rf_wr_en, done at T+2.
- Reset asserted in SWAP2 -> next cycle all outputs 0 and IDLE; no done. start is ignored while busy and in the done cycle.
- Random modes/addresses over 10k operations against a reference model. Bus-exclusivity and done-pulse-width assertions hold throughout.
